// File: rtl/bp_me_pkg.sv
// Shared BedRock ME definitions: processor config, header field layout,
// message types, burst-to-stream FSM states and the stream beat-count helper.
package bp_me_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  // Physical address width supplied by a processor configuration
  function automatic int bp_paddr_width(bp_params_e cfg);
    int w;
    case (cfg)
      e_bp_default_cfg: w = 40;
      default:          w = 40;
    endcase
    return w;
  endfunction

  // Header layout, LSB first: msg_type[3:0], subop[3:0], addr, size[2:0], payload
  localparam int bp_msg_type_width_gp = 4;
  localparam int bp_msg_size_width_gp = 3;
  localparam int hdr_msg_type_lsb_gp  = 0;
  localparam int hdr_addr_lsb_gp      = 8;

  function automatic int bp_hdr_size_lsb(int paddr_w);
    return hdr_addr_lsb_gp + paddr_w;
  endfunction

  function automatic int bp_header_width(int paddr_w, int payload_w);
    return hdr_addr_lsb_gp + paddr_w + bp_msg_size_width_gp + payload_w;
  endfunction

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [0:0] {
    e_ready = 1'b0,
    e_send  = 1'b1
  } bp_me_b2s_state_e;

  // Number of data beats for a message of 2^size bytes, never fewer than one
  function automatic int bp_me_stream_beats(int size, int data_width);
    int bytes;
    int per_beat;
    bytes    = 1 << size;
    per_beat = data_width / 8;
    return (bytes > per_beat) ? (bytes / per_beat) : 1;
  endfunction

endpackage

// File: rtl/bp_me_stream_addr_gen.sv
// Stream beat counter and per-beat address generator. The beat address walks
// in data-beat steps and wraps inside min(message size, block size); bits
// above the wrap window are passed through untouched.
module bp_me_stream_addr_gen
  import bp_me_pkg::*;
  #(parameter int paddr_width_p = 40
  , parameter int data_width_p  = 64
  , parameter int block_width_p = 512
  , localparam int cnt_width_lp = $clog2(block_width_p / data_width_p) + 1
  )
  (input  logic                     clk_i
  , input  logic                     reset_i
  , input  logic [2:0]               size_i
  , input  logic [paddr_width_p-1:0] addr_i
  , input  logic                     clear_i
  , input  logic                     inc_i
  , output logic [cnt_width_lp-1:0]  cnt_o
  , output logic [paddr_width_p-1:0] addr_o
  );

  localparam int data_bytes_lp  = data_width_p / 8;
  localparam int data_shift_lp  = $clog2(data_bytes_lp);
  localparam int block_bytes_lp = block_width_p / 8;

  logic [cnt_width_lp-1:0]  cnt_r;
  logic [paddr_width_p-1:0] msg_bytes;
  logic [paddr_width_p-1:0] wrap_mask;
  logic [paddr_width_p-1:0] step;
  logic [paddr_width_p-1:0] sum;

  // Wrap mask selects the offset bits that advance; carries out of it are dropped
  always_comb begin
    msg_bytes = paddr_width_p'(1) << size_i;
    if (int'(size_i) <= data_shift_lp)
      wrap_mask = '0;
    else if (msg_bytes > paddr_width_p'(block_bytes_lp))
      wrap_mask = paddr_width_p'(block_bytes_lp - 1);
    else
      wrap_mask = msg_bytes - paddr_width_p'(1);
    step   = paddr_width_p'(cnt_r) << data_shift_lp;
    sum    = addr_i + step;
    addr_o = (addr_i & ~wrap_mask) | (sum & wrap_mask);
  end

  // Beat counter: clears at message boundaries, advances per stream handshake
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      cnt_r <= '0;
    else if (clear_i)
      cnt_r <= '0;
    else if (inc_i)
      cnt_r <= cnt_r + 1'b1;
  end

  assign cnt_o = cnt_r;

endmodule

// File: rtl/bp_me_burst_to_stream.sv
// BedRock Burst to BedRock Stream converter. The header is registered once and
// replayed on every outgoing beat with a wrapped per-beat address; data beats
// pass through combinationally. Data-less messages emit a single beat.
module bp_me_burst_to_stream
  import bp_me_pkg::*;
  #(parameter bp_params_e  bp_params_p     = e_bp_default_cfg
  , parameter int          data_width_p    = 64
  , parameter int          payload_width_p = 16
  , parameter int          block_width_p   = 512
  , parameter logic [15:0] payload_mask_p  = '0
  , localparam int paddr_width_lp     = bp_paddr_width(bp_params_p)
  , localparam int bp_header_width_lp = bp_header_width(paddr_width_lp, payload_width_p)
  , localparam int cnt_width_lp       = $clog2(block_width_p / data_width_p) + 1
  )
  (input  logic                          clk_i
  , input  logic                          reset_i
  , input  logic [bp_header_width_lp-1:0] in_msg_header_i
  , input  logic                          in_msg_header_v_i
  , output logic                          in_msg_header_ready_and_o
  , input  logic [data_width_p-1:0]       in_msg_data_i
  , input  logic                          in_msg_data_v_i
  , input  logic                          in_msg_last_i
  , output logic                          in_msg_data_ready_and_o
  , output logic [bp_header_width_lp-1:0] out_msg_header_o
  , output logic [data_width_p-1:0]       out_msg_data_o
  , output logic                          out_msg_v_o
  , output logic                          out_msg_last_o
  , input  logic                          out_msg_ready_and_i
  );

  localparam int size_lsb_lp = bp_hdr_size_lsb(paddr_width_lp);

  bp_me_b2s_state_e              state_r;
  logic [bp_header_width_lp-1:0] header_r;
  logic                          has_data_r;

  logic [2:0]                size_r;
  logic [paddr_width_lp-1:0] addr_r;
  logic [paddr_width_lp-1:0] beat_addr;
  logic [cnt_width_lp-1:0]   cnt;
  logic [cnt_width_lp-1:0]   last_cnt;
  logic                      header_hs;
  logic                      stream_hs;
  logic                      last_hs;
  logic                      data_hs;

  assign size_r = header_r[size_lsb_lp +: bp_msg_size_width_gp];
  assign addr_r = header_r[hdr_addr_lsb_gp +: paddr_width_lp];

  // Handshake outputs; header_ready also rises on the final beat so the next
  // header can be taken in the same cycle without a bubble
  always_comb begin
    in_msg_header_ready_and_o = 1'b0;
    in_msg_data_ready_and_o   = 1'b0;
    out_msg_v_o               = 1'b0;
    out_msg_last_o            = 1'b0;
    out_msg_data_o            = '0;
    case (state_r)
      e_ready: in_msg_header_ready_and_o = 1'b1;
      e_send: begin
        if (has_data_r) begin
          out_msg_v_o             = in_msg_data_v_i;
          out_msg_last_o          = in_msg_last_i;
          out_msg_data_o          = in_msg_data_i;
          in_msg_data_ready_and_o = out_msg_ready_and_i;
        end else begin
          out_msg_v_o    = 1'b1;
          out_msg_last_o = 1'b1;
        end
        in_msg_header_ready_and_o = out_msg_v_o & out_msg_ready_and_i & out_msg_last_o;
      end
      default: ;
    endcase
  end

  assign header_hs = in_msg_header_v_i & in_msg_header_ready_and_o;
  assign stream_hs = out_msg_v_o & out_msg_ready_and_i;
  assign last_hs   = stream_hs & out_msg_last_o;
  assign data_hs   = in_msg_data_v_i & in_msg_data_ready_and_o;

  // Header register, data flag and state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= e_ready;
      header_r   <= '0;
      has_data_r <= 1'b0;
    end else if (header_hs) begin
      state_r    <= e_send;
      header_r   <= in_msg_header_i;
      has_data_r <= payload_mask_p[in_msg_header_i[hdr_msg_type_lsb_gp +: bp_msg_type_width_gp]];
    end else if (last_hs) begin
      state_r <= e_ready;
    end
  end

  bp_me_stream_addr_gen
    #(.paddr_width_p(paddr_width_lp)
    , .data_width_p (data_width_p)
    , .block_width_p(block_width_p)
    )
    u_addr_gen
    (.clk_i  (clk_i)
    , .reset_i(reset_i)
    , .size_i (size_r)
    , .addr_i (addr_r)
    , .clear_i(header_hs | last_hs)
    , .inc_i  (stream_hs)
    , .cnt_o  (cnt)
    , .addr_o (beat_addr)
    );

  // Replay the registered header with the current beat address substituted
  always_comb begin
    out_msg_header_o = header_r;
    out_msg_header_o[hdr_addr_lsb_gp +: paddr_width_lp] = beat_addr;
  end

  assign last_cnt = cnt_width_lp'(bp_me_stream_beats(int'(size_r), data_width_p) - 1);

  last_beat_matches_count: assert property (@(posedge clk_i) disable iff (reset_i)
    data_hs |-> (in_msg_last_i == (cnt == last_cnt)));

endmodule

// File: tb/tb_bp_me_burst_to_stream.sv
// Self-checking bench for bp_me_burst_to_stream: directed scenarios followed by
// randomized traffic, checked against a queue-based model of the Stream output.
module tb_bp_me_burst_to_stream;
  import bp_me_pkg::*;

  localparam int dw = 64;
  localparam int pw = 16;
  localparam int aw = 40;
  localparam int hw = 4 + 4 + aw + 3 + pw;

  typedef struct {
    logic [hw-1:0] hdr;
    logic [dw-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [hw-1:0] hdr = '0;
  logic          hv = 1'b0;
  logic          hready;
  logic [dw-1:0] din = '0;
  logic          dv = 1'b0;
  logic          dlast = 1'b0;
  logic          dready;
  logic [hw-1:0] out_hdr;
  logic [dw-1:0] out_data;
  logic          out_v;
  logic          out_last;
  logic          ordy = 1'b1;

  int checks = 0;
  int failures = 0;
  int beats_seen = 0;
  int rmode = 0;
  int dgap = 0;

  logic [hw-1:0] hdr_q[$];
  logic [dw:0]   data_q[$];
  beat_t         exp_q[$];

  always #5 clk = ~clk;

  bp_me_burst_to_stream
    #(.bp_params_p    (e_bp_default_cfg)
    , .data_width_p   (dw)
    , .payload_width_p(pw)
    , .block_width_p  (512)
    , .payload_mask_p (16'h000A)
    )
    dut
    (.clk_i                    (clk)
    , .reset_i                  (rst)
    , .in_msg_header_i          (hdr)
    , .in_msg_header_v_i        (hv)
    , .in_msg_header_ready_and_o(hready)
    , .in_msg_data_i            (din)
    , .in_msg_data_v_i          (dv)
    , .in_msg_last_i            (dlast)
    , .in_msg_data_ready_and_o  (dready)
    , .out_msg_header_o         (out_hdr)
    , .out_msg_data_o           (out_data)
    , .out_msg_v_o              (out_v)
    , .out_msg_last_o           (out_last)
    , .out_msg_ready_and_i      (ordy)
    );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [hw-1:0] mk_hdr(input logic [3:0] t, input logic [3:0] sub,
                                           input logic [aw-1:0] a, input logic [2:0] sz,
                                           input logic [pw-1:0] pl);
    return {pl, sz, a, sub, t};
  endfunction

  // Beat address from plain modular arithmetic on the wrap window
  function automatic logic [aw-1:0] exp_addr(input logic [aw-1:0] a, input int size, input int k);
    longint unsigned bytes, win, av, base, off;
    av    = 64'(a);
    bytes = 64'd1 << size;
    if (bytes <= 64'd8) return a;
    win  = (bytes < 64'd64) ? bytes : 64'd64;
    base = av - (av % win);
    off  = ((av % win) + 64'(k) * 64'd8) % win;
    return aw'(base + off);
  endfunction

  task automatic push_msg(input logic [3:0] t, input logic [aw-1:0] a, input int size);
    logic [hw-1:0] h;
    logic [dw-1:0] d;
    logic [3:0]    sub;
    logic [pw-1:0] pl;
    beat_t         b;
    int            nb;
    bit            has;
    sub = 4'($urandom_range(0, 15));
    pl  = pw'($urandom);
    h   = mk_hdr(t, sub, a, 3'(size), pl);
    hdr_q.push_back(h);
    has = (t == e_bedrock_mem_wr) || (t == e_bedrock_mem_uc_wr);
    nb  = has ? (((1 << size) > 8) ? (1 << size) / 8 : 1) : 1;
    for (int k = 0; k < nb; k++) begin
      d = has ? {$urandom, $urandom} : '0;
      if (has) data_q.push_back({(k == nb - 1), d});
      b.hdr  = mk_hdr(t, sub, exp_addr(a, size, k), 3'(size), pl);
      b.data = d;
      b.last = (k == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || hdr_q.size() > 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(exp_q.size()), 128'd0);
    repeat (2) @(negedge clk);
  endtask

  // Header driver: presents queued headers, holding each until accepted
  initial begin
    logic hhs;
    forever begin
      @(negedge clk);
      hhs = hv && hready && !rst;
      @(posedge clk);
      #1;
      if (rst) hv = 1'b0;
      else if (hhs || !hv) begin
        if (hdr_q.size() > 0) begin
          hdr = hdr_q.pop_front();
          hv  = 1'b1;
        end else hv = 1'b0;
      end
    end
  end

  // Data driver: presents queued beats, optionally with idle gaps between them
  initial begin
    logic        dhs;
    logic [dw:0] e;
    forever begin
      @(negedge clk);
      dhs = dv && dready && !rst;
      @(posedge clk);
      #1;
      if (rst) dv = 1'b0;
      else if (dhs || !dv) begin
        if (data_q.size() > 0 && !(dgap != 0 && $urandom_range(0, 3) == 0)) begin
          e     = data_q.pop_front();
          din   = e[dw-1:0];
          dlast = e[dw];
          dv    = 1'b1;
        end else dv = 1'b0;
      end
    end
  end

  // Output ready pattern: steady, alternating or random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       ordy = 1'b1;
        1:       ordy = ~ordy;
        default: ordy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard: every Stream handshake must match the next expected beat
  always @(negedge clk) begin
    if (!rst && out_v && ordy) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_beat observed_hdr=%0h expected=none", out_hdr);
      end
      if (exp_q.size() > 0) begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_hdr", 128'(out_hdr), 128'(b.hdr));
        chk("beat_data", 128'(out_data), 128'(b.data));
        chk("beat_last", 128'(out_last), 128'(b.last));
        beats_seen++;
      end
    end
  end

  initial begin
    int  n;
    bit  found;
    int  base;
    logic [3:0]    types [4];
    logic [aw-1:0] ra;
    types[0] = e_bedrock_mem_rd;
    types[1] = e_bedrock_mem_wr;
    types[2] = e_bedrock_mem_uc_rd;
    types[3] = e_bedrock_mem_uc_wr;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hready", 128'(hready), 128'd1);
    chk("rst_dready", 128'(dready), 128'd0);
    chk("rst_out_v", 128'(out_v), 128'd0);
    chk("rst_out_last", 128'(out_last), 128'd0);
    chk("rst_out_hdr", 128'(out_hdr), 128'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // 1: read 64B, single data-less beat one cycle after header accept
    push_msg(e_bedrock_mem_rd, 40'h80_0000_0040, 6);
    n = 0;
    do begin @(negedge clk); n++; end while (!(hv && hready) && n < 20);
    @(negedge clk);
    chk("t1_latency_v", 128'(out_v), 128'd1);
    chk("t1_addr", 128'(out_hdr[8 +: aw]), 128'h80_0000_0040);
    chk("t1_data", 128'(out_data), 128'd0);
    chk("t1_last", 128'(out_last), 128'd1);
    drain("t1_drain");

    // 2: write 64B aligned, data held off until the header is taken
    push_msg(e_bedrock_mem_wr, 40'h80_0000_0040, 6);
    n = 0;
    do begin @(negedge clk); n++; end while (!(hv && hready) && n < 20);
    chk("t2_data_held", 128'(dready), 128'd0);
    drain("t2_drain");

    // 3: write 64B starting mid-block, wraps back to 0x40
    push_msg(e_bedrock_mem_wr, 40'h80_0000_0070, 6);
    drain("t3_drain");

    // 4: write 4B, one beat, counter back to zero
    push_msg(e_bedrock_mem_wr, 40'h00_0000_1004, 2);
    drain("t4_drain");
    chk("t4_cnt", 128'(dut.u_addr_gen.cnt_r), 128'd0);

    // 5: alternating out_ready with a queued follow-on header
    rmode = 1;
    push_msg(e_bedrock_mem_wr, 40'h80_0000_0040, 6);
    push_msg(e_bedrock_mem_rd, 40'h00_0000_2000, 3);
    found = 1'b0;
    n = 0;
    while (!found && n < 300) begin
      @(negedge clk);
      n++;
      if (out_v && ordy && out_last) found = 1'b1;
      else if (out_v) chk("t5_dready", 128'(dready), 128'(ordy));
    end
    chk("t5_last_seen", 128'(found), 128'd1);
    chk("t5_b2b_hready", 128'(hready), 128'd1);
    chk("t5_b2b_hv", 128'(hv), 128'd1);
    @(negedge clk);
    chk("t5_next_v", 128'(out_v), 128'd1);
    chk("t5_next_addr", 128'(out_hdr[8 +: aw]), 128'h00_0000_2000);
    drain("t5_drain");
    rmode = 0;

    // 6: reset in the middle of an 8-beat write
    base = beats_seen;
    push_msg(e_bedrock_mem_wr, 40'h80_0000_0040, 6);
    n = 0;
    do begin @(posedge clk); n++; end while (beats_seen < base + 3 && n < 100);
    #2 rst = 1'b1;
    #1 chk("t6_out_v_drop", 128'(out_v), 128'd0);
    data_q.delete();
    exp_q.delete();
    hdr_q.delete();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t6_hready", 128'(hready), 128'd1);
    chk("t6_dready", 128'(dready), 128'd0);
    push_msg(e_bedrock_mem_wr, 40'h80_0000_0080, 6);
    drain("t6_drain");

    // Random traffic: mixed types, all sizes, random addresses, stalls and gaps
    rmode = 2;
    dgap  = 1;
    for (int unsigned i = 0; i < 40; i++) begin
      ra = {8'($urandom_range(0, 255)), 32'($urandom)};
      push_msg(types[$urandom_range(0, 3)], ra, int'($urandom_range(0, 7)));
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
